// File: rtl/key_filter_pkg.sv
// key_pkg: shared state encoding, default timing constants and key polarity
package key_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_FILT, DOWN, REL_FILT} key_state_t;
  localparam int KEY_DEBOUNCE_CYC = 1_000_000;
  localparam int KEY_LONG_CYC = 50_000_000;
  localparam logic KEY_ACTIVE = 1'b0;
endpackage

// File: rtl/key_filter_if.sv
// key_filter_if: raw key pins in, debounced levels and event pulses out
interface key_filter_if #(parameter int N_KEYS = 3);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  modport master (output key_in, input key_level, key_press, key_release, key_long);
  modport slave (input key_in, output key_level, key_press, key_release, key_long);
endinterface

// File: rtl/key_filter_ch.sv
// key_filter_ch: one key channel - synchroniser, debounce FSM, hold counter
module key_filter_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC,
  parameter int LONG_CYC = KEY_LONG_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] H_MAX = HW'(LONG_CYC);
  logic [1:0] sync;
  key_state_t state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic level_n, press_n, release_n, long_n;
  logic down;
  logic held;
  assign down = sync[1] == KEY_ACTIVE;
  assign held = state == DOWN || state == REL_FILT;
  // state, counters and all outputs are registered; reset forces the released idle view
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      state <= IDLE;
      dcnt <= '0;
      hcnt <= '0;
      key_level <= ~KEY_ACTIVE;
      key_press <= 1'b0;
      key_release <= 1'b0;
      key_long <= 1'b0;
    end else begin
      sync <= {sync[0], key_in};
      state <= state_n;
      dcnt <= dcnt_n;
      hcnt <= hcnt_n;
      key_level <= level_n;
      key_press <= press_n;
      key_release <= release_n;
      key_long <= long_n;
    end
  end
  // next state: hold time keeps counting through release bounces, long fires once at saturation edge
  always_comb begin
    state_n = state;
    dcnt_n = dcnt;
    hcnt_n = held ? (hcnt == H_MAX ? hcnt : hcnt + 1'b1) : hcnt;
    level_n = key_level;
    press_n = 1'b0;
    release_n = 1'b0;
    long_n = held && hcnt == H_LAST;
    case (state)
      IDLE: if (down) begin
        state_n = PRESS_FILT;
        dcnt_n = '0;
      end
      PRESS_FILT: if (!down) state_n = IDLE;
      else if (dcnt == D_LAST) begin
        state_n = DOWN;
        level_n = KEY_ACTIVE;
        press_n = 1'b1;
        hcnt_n = '0;
      end else dcnt_n = dcnt + 1'b1;
      DOWN: if (!down) begin
        state_n = REL_FILT;
        dcnt_n = '0;
      end
      REL_FILT: if (down) state_n = DOWN;
      else if (dcnt == D_LAST) begin
        state_n = IDLE;
        level_n = ~KEY_ACTIVE;
        release_n = 1'b1;
      end else dcnt_n = dcnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/key_filter.sv
// key_filter: N independent debounced key channels behind one interface
module key_filter
  import key_pkg::*;
#(
  parameter int N_KEYS = 3,
  parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC,
  parameter int LONG_CYC = KEY_LONG_CYC
) (
  input logic clk,
  input logic rst_n,
  key_filter_if.slave bus
);
  logic [N_KEYS-1:0] level, press, rel, long_p;
  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_filter_ch #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .LONG_CYC(LONG_CYC)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .key_in(bus.key_in[g]),
      .key_level(level[g]),
      .key_press(press[g]),
      .key_release(rel[g]),
      .key_long(long_p[g])
    );
  end
  assign bus.key_level = level;
  assign bus.key_press = press;
  assign bus.key_release = rel;
  assign bus.key_long = long_p;
endmodule
